// File: rtl/tile_dispatcher.sv
// tile_dispatcher: walks a square IMG_SIZE x IMG_SIZE image in overlapping
// 6x6 tiles (origin step 4), hands each tile to an external engine and
// writes the returned 4x4 result into an (IMG_SIZE-2)-wide output image.
// Optional watchdog on the engine: define TILE_DISPATCHER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | reading the 36 words of the current tile
// LAUNCH | one-cycle tile_start pulse
// WAIT   | waiting for tile_done (or watchdog expiry)
// WRITE  | writing the 16 result words
// DONE   | one-cycle completion pulse
module tile_dispatcher #(
  parameter int IMG_SIZE       = 10,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     img_rd_en,
  output logic [ADDR_W-1:0]        img_rd_addr,
  input  logic [31:0]              img_rd_data,
  output logic                     tile_start,
  output logic [0:5][0:5][31:0]    tile_out,
  input  logic                     tile_done,
  input  logic [0:3][0:3][31:0]    tile_result,
  output logic                     res_wr_en,
  output logic [ADDR_W-1:0]        res_wr_addr,
  output logic [31:0]              res_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ORG = ADDR_W'(IMG_SIZE - 6);
  localparam logic [ADDR_W-1:0] IN_W     = ADDR_W'(IMG_SIZE);
  localparam logic [ADDR_W-1:0] OUT_W    = ADDR_W'(IMG_SIZE - 2);

  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [5:0]              fcnt;
  logic [2:0]              frow, fcol;
  logic                    cap_vld;
  logic [2:0]              cap_row, cap_col;
  logic [3:0]              wcnt;
  logic [ADDR_W-1:0]       ty, tx;
  logic [0:3][0:3][31:0]   res_q;
  logic                    last_tile;
  logic                    wd_expire;

  assign last_tile = (ty == LAST_ORG) && (tx == LAST_ORG);

`ifdef TILE_DISPATCHER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign wd_expire = (state == WAIT) && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;

  // Watchdog: counts WAIT cycles from zero on each entry; expiry is sticky in err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && start)
        err_q <= 1'b0;
      if (state != WAIT)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      if (state == WAIT && !tile_done && wd_expire)
        err_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and all per-cycle outputs; addresses/data read as 0 when idle.
  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    img_rd_en   = 1'b0;
    img_rd_addr = '0;
    tile_start  = 1'b0;
    res_wr_en   = 1'b0;
    res_wr_addr = '0;
    res_wr_data = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy = 1'b1;
        if (fcnt < 6'd36) begin
          img_rd_en   = 1'b1;
          img_rd_addr = (ty + ADDR_W'(frow)) * IN_W + tx + ADDR_W'(fcol);
        end else begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        busy       = 1'b1;
        tile_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (tile_done)      state_nxt = WRITE;
        else if (wd_expire) state_nxt = DONE;
      end
      WRITE: begin
        busy        = 1'b1;
        res_wr_en   = 1'b1;
        res_wr_addr = (ty + ADDR_W'(wcnt[3:2])) * OUT_W + tx + ADDR_W'(wcnt[1:0]);
        res_wr_data = res_q[wcnt[3:2]][wcnt[1:0]];
        if (wcnt == 4'd15) state_nxt = last_tile ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: fetch/write counters, tile origin, captured tile and latched result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt     <= '0;
      frow     <= '0;
      fcol     <= '0;
      cap_vld  <= 1'b0;
      cap_row  <= '0;
      cap_col  <= '0;
      wcnt     <= '0;
      ty       <= '0;
      tx       <= '0;
      res_q    <= '0;
      tile_out <= '0;
    end else begin
      // Read data returns one cycle after the request, so remember where it goes.
      cap_vld <= img_rd_en;
      cap_row <= frow;
      cap_col <= fcol;
      if (cap_vld)
        tile_out[cap_row][cap_col] <= img_rd_data;
      case (state)
        IDLE: begin
          fcnt <= '0;
          frow <= '0;
          fcol <= '0;
          ty   <= '0;
          tx   <= '0;
        end
        FETCH: begin
          if (fcnt < 6'd36) begin
            fcnt <= fcnt + 1'b1;
            if (fcol == 3'd5) begin
              fcol <= '0;
              frow <= frow + 1'b1;
            end else begin
              fcol <= fcol + 1'b1;
            end
          end
        end
        LAUNCH: begin
          fcnt <= '0;
          frow <= '0;
          fcol <= '0;
          wcnt <= '0;
        end
        WAIT: begin
          wcnt <= '0;
          if (tile_done) res_q <= tile_result;
        end
        WRITE: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == 4'd15 && !last_tile) begin
            if (tx == LAST_ORG) begin
              tx <= '0;
              ty <= ty + ADDR_W'(4);
            end else begin
              tx <= tx + ADDR_W'(4);
            end
          end
        end
        DONE: begin
          ty <= '0;
          tx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
